// File: rtl/hdlc_seq_pkg.sv
// Shared types and constants for the HDLC Tx sequencer: FSM states, HDLC register
// map, Tx_SC bit positions and per-frame completion codes.
package hdlc_seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        DRAIN = 3'd2,
        POLL  = 3'd3,
        ABORT = 3'd4,
        DONE  = 3'd5
    } state_e;

    localparam logic [2:0] TX_SC   = 3'd0;
    localparam logic [2:0] TX_BUFF = 3'd1;

    localparam int SC_DONE    = 0;
    localparam int SC_ENABLE  = 1;
    localparam int SC_ABORT   = 2;
    localparam int SC_ABORTED = 3;

    typedef enum logic [1:0] {
        ST_SENT     = 2'b00,
        ST_ABORTED  = 2'b01,
        ST_OVERSIZE = 2'b10,
        ST_TIMEOUT  = 2'b11
    } status_e;

    // Tx_SC write value with only the given command bit set.
    function automatic logic [7:0] sc_cmd(input int bit_idx);
        return 8'd1 << bit_idx;
    endfunction

endpackage

// File: rtl/hdlc_poll_timer.sv
// Poll-gap strobe and stuck-transmitter timeout counters; both restart from zero
// when the sequencer enters POLL and only advance while it stays there.
module hdlc_poll_timer #(
    parameter int POLL_GAP = 4,
    parameter int TIMEOUT  = 4096
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic en_i,
    output logic poll_o,
    output logic timeout_o
);
    localparam int GW = $clog2(POLL_GAP + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [GW-1:0] gap_q, gap_d;
    logic [TW-1:0] to_q, to_d;

    always_comb begin
        gap_d = gap_q;
        to_d  = to_q;
        if (clear_i) begin
            gap_d = '0;
            to_d  = '0;
        end else if (en_i) begin
            gap_d = (gap_q == GW'(POLL_GAP - 1)) ? '0 : gap_q + 1'b1;
            if (to_q != TW'(TIMEOUT - 1)) begin
                to_d = to_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            gap_q <= '0;
            to_q  <= '0;
        end else begin
            gap_q <= gap_d;
            to_q  <= to_d;
        end
    end

    // Strobe one cycle early so the registered read lands exactly POLL_GAP after entry.
    assign poll_o    = en_i && (gap_q == GW'(POLL_GAP - 1));
    assign timeout_o = en_i && (to_q == TW'(TIMEOUT - 1));

endmodule

// File: rtl/hdlc_tx_sequencer.sv
// Bus master feeding one frame at a time into the HDLC Tx buffer, then enabling,
// polling and, when needed, aborting the transmitter.
module hdlc_tx_sequencer
    import hdlc_seq_pkg::*;
#(
    parameter int MAX_FRAME = 126,
    parameter int POLL_GAP  = 4,
    parameter int TIMEOUT   = 4096
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       s_valid,
    input  logic [7:0] s_data,
    input  logic       s_last,
    output logic       s_ready,
    input  logic       abort_req,
    output logic       busy,
    output logic       done,
    output logic [1:0] status,
    output logic [2:0] Address,
    output logic       WriteEnable,
    output logic       ReadEnable,
    output logic [7:0] DataIn,
    input  logic [7:0] DataOut,
    output state_e     dbg_state
);
    state_e     state_q, state_d;
    logic [6:0] cnt_q, cnt_d;
    logic       last_q, last_d;     // last byte written, Tx_Enable still owed
    logic [1:0] wait_q, wait_d;
    logic [1:0] status_q, status_d;
    logic       we_q, we_d, re_q, re_d, chk_q;
    logic [2:0] addr_q, addr_d;
    logic [7:0] din_q, din_d;
    logic       accept, in_poll, timer_clear, poll_strobe, poll_timeout;
    logic       unused_dataout;

    assign s_ready        = (state_q == IDLE) || (state_q == DRAIN) || (state_q == LOAD && !last_q);
    assign accept         = s_valid && s_ready;
    assign in_poll        = (state_q == POLL);
    assign timer_clear    = (state_d == POLL) && (state_q != POLL);
    assign unused_dataout = ^DataOut[7:1];

    hdlc_poll_timer #(.POLL_GAP(POLL_GAP), .TIMEOUT(TIMEOUT)) u_timer (
        .clk_i    (Clk),
        .rst_i    (Rst),
        .clear_i  (timer_clear),
        .en_i     (in_poll),
        .poll_o   (poll_strobe),
        .timeout_o(poll_timeout)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        wait_d   = wait_q;
        status_d = status_q;
        we_d     = 1'b0;
        re_d     = 1'b0;
        addr_d   = '0;
        din_d    = '0;
        case (state_q)
            IDLE: if (accept) begin
                state_d  = LOAD;
                cnt_d    = 7'd1;
                last_d   = s_last;
                status_d = ST_SENT;
                we_d     = 1'b1;
                addr_d   = TX_BUFF;
                din_d    = s_data;
            end
            LOAD: begin
                // An abort consumes any coincident beat without writing it.
                if (abort_req) begin
                    status_d = ST_ABORTED;
                    state_d  = (last_q || (accept && s_last)) ? ABORT : DRAIN;
                end else if (last_q) begin
                    last_d  = 1'b0;
                    state_d = POLL;
                    we_d    = 1'b1;
                    addr_d  = TX_SC;
                    din_d   = sc_cmd(SC_ENABLE);
                end else if (accept) begin
                    if (cnt_q != 7'h7F) cnt_d = cnt_q + 7'd1;
                    if (cnt_q >= 7'(MAX_FRAME)) begin
                        status_d = ST_OVERSIZE;
                        state_d  = s_last ? ABORT : DRAIN;
                    end else begin
                        last_d = s_last;
                        we_d   = 1'b1;
                        addr_d = TX_BUFF;
                        din_d  = s_data;
                    end
                end
            end
            DRAIN: if (accept && s_last) state_d = ABORT;
            POLL: begin
                if (chk_q && DataOut[SC_DONE]) begin
                    status_d = ST_SENT;
                    state_d  = DONE;
                end else if (abort_req) begin
                    status_d = ST_ABORTED;
                    state_d  = ABORT;
                end else if (poll_timeout) begin
                    status_d = ST_TIMEOUT;
                    state_d  = ABORT;
                end else if (poll_strobe) begin
                    re_d   = 1'b1;
                    addr_d = TX_SC;
                end
            end
            ABORT: begin
                if (wait_q == 2'd2) state_d = DONE;
                else wait_d = wait_q + 2'd1;
            end
            DONE: begin
                last_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (state_d == ABORT && state_q != ABORT) begin
            wait_d = '0;
            we_d   = 1'b1;
            re_d   = 1'b0;
            addr_d = TX_SC;
            din_d  = sc_cmd(SC_ABORT);
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            last_q   <= 1'b0;
            wait_q   <= '0;
            status_q <= '0;
            we_q     <= 1'b0;
            re_q     <= 1'b0;
            chk_q    <= 1'b0;
            addr_q   <= '0;
            din_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            wait_q   <= wait_d;
            status_q <= status_d;
            we_q     <= we_d;
            re_q     <= re_d;
            chk_q    <= re_q;
            addr_q   <= addr_d;
            din_q    <= din_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign status      = status_q;
    assign Address     = addr_q;
    assign WriteEnable = we_q;
    assign ReadEnable  = re_q;
    assign DataIn      = din_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_hdlc_tx_sequencer.sv
// Randomized frame traffic against a frame-level reference model; a negedge monitor
// pops expected bus writes and completion codes and checks cycle spacing.
module tb_hdlc_tx_sequencer;
  import hdlc_seq_pkg::*;

  localparam int MAX_FRAME = 126;
  localparam int POLL_GAP  = 4;
  localparam int TIMEOUT   = 4096;

  logic       Clk, Rst, s_valid, s_last, s_ready, abort_req, busy, done;
  logic [7:0] s_data, DataIn, DataOut;
  logic [1:0] status;
  logic [2:0] Address;
  logic       WriteEnable, ReadEnable;
  state_e     dbg_state;

  hdlc_tx_sequencer #(.MAX_FRAME(MAX_FRAME), .POLL_GAP(POLL_GAP), .TIMEOUT(TIMEOUT)) dut (
    .Clk(Clk), .Rst(Rst), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .s_ready(s_ready), .abort_req(abort_req), .busy(busy), .done(done), .status(status),
    .Address(Address), .WriteEnable(WriteEnable), .ReadEnable(ReadEnable),
    .DataIn(DataIn), .DataOut(DataOut), .dbg_state(dbg_state)
  );

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks = 0, failures = 0;
  int cyc = 0;
  always @(posedge Clk) cyc++;

  logic [12:0] exp_q[$];
  logic [7:0]  fixed_q[$];
  int done_cnt = 0, enable_cnt = 0;
  int last_acc_cyc = 0, last_buf_cyc = 0, enable_cyc = 0, last_read_cyc = 0, abort_cyc = 0;
  bit exp_tmo = 0, prev_done = 0, rd_last = 0;
  int done_after = 0, reads_n = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic void push_wr(input logic [2:0] a, input logic [7:0] d);
    exp_q.push_back({2'd0, a, d});
  endfunction

  function automatic void push_done(input logic [1:0] st);
    exp_q.push_back({2'd1, 3'd0, 6'd0, st});
  endfunction

  task automatic sb_pop(input string name, input logic [12:0] got);
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s unexpected got=%0h exp=none t=%0t", name, got, $time);
    end else begin
      chk(name, 32'(got), 32'(exp_q.pop_front()));
    end
  endtask

  // HDLC Tx_SC read responder: DataOut valid the cycle after ReadEnable, noise otherwise.
  always @(negedge Clk) rd_last = ReadEnable;
  always @(posedge Clk) begin
    #1;
    if (rd_last) begin
      reads_n++;
      DataOut = {7'($urandom), (done_after != 0 && reads_n >= done_after)};
    end else begin
      DataOut = 8'($urandom);
    end
  end

  // monitor / scoreboard
  always @(negedge Clk) begin
    if (Rst) begin
      prev_done = 0;
    end else begin
      chk("we_re_excl", 32'(WriteEnable & ReadEnable), 0);
      if (WriteEnable) begin
        sb_pop("bus_write", {2'd0, Address, DataIn});
        if (Address == TX_BUFF) begin
          chk("buff_latency", cyc, last_acc_cyc + 1);
          last_buf_cyc = cyc;
        end else if (DataIn == 8'h02) begin
          chk("enable_latency", cyc, last_buf_cyc + 1);
          enable_cyc    = cyc;
          last_read_cyc = cyc;
          enable_cnt++;
        end else if (DataIn == 8'h04) begin
          abort_cyc = cyc;
          if (exp_tmo) chk("timeout_gap", cyc - enable_cyc, TIMEOUT);
        end
      end
      if (ReadEnable) begin
        chk("read_addr", 32'(Address), 0);
        chk("poll_gap", cyc - last_read_cyc, POLL_GAP);
        last_read_cyc = cyc;
      end
      if (done) begin
        sb_pop("done_status", {2'd1, 3'd0, 6'd0, status});
        chk("done_busy", 32'(busy), 1);
        if (status == 2'b00) chk("done_latency", cyc, last_read_cyc + 2);
        else chk("abort_to_done", cyc, abort_cyc + 3);
        done_cnt++;
      end
      if (prev_done) chk("busy_drop", 32'(busy), 0);
      prev_done = done;
      if (s_valid && s_ready) last_acc_cyc = cyc;
    end
  end

  // driver tasks
  task automatic idle_cycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_accept();
    bit acc = 0;
    for (int c = 0; c < 64 && !acc; c++) begin
      @(negedge Clk);
      acc = s_ready;
      @(posedge Clk);
      #1;
    end
    if (!acc) chk("accept_wait", 0, 1);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_s_ready"}, 32'(s_ready), 1);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_status"}, 32'(status), 0);
    chk({tag, "_we"}, 32'(WriteEnable), 0);
    chk({tag, "_re"}, 32'(ReadEnable), 0);
    chk({tag, "_addr"}, 32'(Address), 0);
    chk({tag, "_din"}, 32'(DataIn), 0);
  endtask

  // n beats; abort_k: beat coincident with (or, if gap, preceded by) abort_req, 0 = none;
  // d_after: Tx_Done on that read, 0 = never.
  task automatic send_frame(input int n, input int abort_k, input bit abort_gap,
                            input bit poll_abort, input int d_after, input bit rst_poll);
    logic [7:0] data[$];
    int start_done, start_en;
    if (fixed_q.size() == n) data = fixed_q;
    else for (int i = 0; i < n; i++) data.push_back(8'($urandom));
    // reference model of the resulting bus traffic
    exp_tmo = 0;
    if (abort_k >= 2 && abort_k <= n) begin
      for (int i = 0; i < abort_k - 1; i++) push_wr(3'd1, data[i]);
      push_wr(3'd0, 8'h04);
      push_done(2'b01);
    end else if (n > MAX_FRAME) begin
      for (int i = 0; i < MAX_FRAME; i++) push_wr(3'd1, data[i]);
      push_wr(3'd0, 8'h04);
      push_done(2'b10);
    end else begin
      for (int i = 0; i < n; i++) push_wr(3'd1, data[i]);
      push_wr(3'd0, 8'h02);
      if (rst_poll) begin
      end else if (poll_abort) begin
        push_wr(3'd0, 8'h04);
        push_done(2'b01);
      end else if (d_after == 0) begin
        push_wr(3'd0, 8'h04);
        push_done(2'b11);
        exp_tmo = 1;
      end else begin
        push_done(2'b00);
      end
    end
    done_after = d_after;
    reads_n    = 0;
    start_done = done_cnt;
    start_en   = enable_cnt;
    for (int i = 1; i <= n; i++) begin
      repeat ($urandom_range(0, 2)) idle_cycle();
      if (abort_gap && i == abort_k) begin
        abort_req = 1'b1;
        idle_cycle();
        abort_req = 1'b0;
      end
      s_valid   = 1'b1;
      s_data    = data[i-1];
      s_last    = (i == n);
      abort_req = (!abort_gap && i == abort_k);
      wait_accept();
      s_valid   = 1'b0;
      s_last    = 1'b0;
      abort_req = 1'b0;
    end
    if (poll_abort || rst_poll) begin
      for (int c = 0; c < 400 && enable_cnt == start_en; c++) idle_cycle();
      chk("enable_wait", 32'(enable_cnt != start_en), 1);
      repeat ($urandom_range(1, 10)) idle_cycle();
      if (rst_poll) begin
        Rst = 1'b1;
        exp_q.delete();
        @(negedge Clk);
        check_idle_outputs("rst_poll");
        idle_cycle();
        Rst = 1'b0;
        return;
      end
      abort_req = 1'b1;
      idle_cycle();
      abort_req = 1'b0;
    end
    for (int c = 0; c < TIMEOUT + 400 && done_cnt == start_done; c++) idle_cycle();
    chk("done_wait", 32'(done_cnt != start_done), 1);
    repeat ($urandom_range(1, 3)) idle_cycle();
  endtask

  initial begin
    #900_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    Rst = 1'b1;
    s_valid = 1'b0;
    s_data = '0;
    s_last = 1'b0;
    abort_req = 1'b0;
    DataOut = '0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check_idle_outputs("reset");
    chk("reset_state", 32'(dbg_state), 32'(IDLE));
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    idle_cycle();

    fixed_q = '{8'h7E, 8'hFF, 8'h01};
    send_frame(3, 0, 0, 0, 1, 0);
    fixed_q.delete();
    send_frame(127, 0, 0, 0, 1, 0);
    send_frame(130, 0, 0, 0, 2, 0);
    send_frame(20, 6, 1, 0, 1, 0);
    send_frame(5, 0, 0, 0, 0, 0);
    send_frame(8, 8, 0, 0, 1, 0);
    send_frame(10, 4, 0, 0, 1, 0);
    send_frame(6, 0, 0, 1, 0, 0);
    send_frame(4, 0, 0, 0, 0, 1);
    send_frame(4, 0, 0, 0, 2, 0);

    for (int f = 0; f < 14; f++) begin
      int n, mode;
      n = $urandom_range(2, 24);
      mode = $urandom_range(0, 4);
      case (mode)
        0: send_frame(n, 0, 0, 0, $urandom_range(1, 3), 0);
        1: send_frame(n, $urandom_range(2, n), 0, 0, 1, 0);
        2: send_frame(n, $urandom_range(2, n), 1, 0, 1, 0);
        3: send_frame(n, 0, 0, 1, 0, 0);
        default: send_frame($urandom_range(127, 131), 0, 0, 0, 1, 0);
      endcase
    end

    repeat (5) idle_cycle();
    chk("exp_q_empty", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
